// File: rtl/plotter_pkg.sv
// Shared constants, types and small helpers for the sprite plotter.
// Sprite geometry and colours are fixed here so the lane mapper and the FSM agree.
package plotter_pkg;

  localparam logic [7:0] LANE_BASE     = 8'd24;
  localparam logic [7:0] LANE_PITCH    = 8'd32;
  localparam logic [6:0] PRESS_Y0      = 7'd16;
  localparam logic [6:0] GARB_Y0       = 7'd80;
  localparam int         PRESS_SIZE    = 16;
  localparam int         GARB_SIZE     = 8;
  localparam logic [2:0] PRESS_MAX_POS = 3'd5;
  localparam logic [2:0] GARB_MAX_POS  = 3'd3;

  localparam logic [2:0] COLOUR_BLACK  = 3'b000;
  localparam logic [2:0] COLOUR_PRESS  = 3'b100;
  localparam logic [2:0] COLOUR_GARB   = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       item;
    logic       erase;
    logic [2:0] position;
  } req_t;

  // Index of the last column/row of a sprite (sprites are square).
  function automatic logic [3:0] last_index(input logic item);
    return item ? 4'(PRESS_SIZE - 1) : 4'(GARB_SIZE - 1);
  endfunction

  function automatic logic [2:0] sprite_colour(input logic item, input logic erase);
    if (erase) return COLOUR_BLACK;
    return item ? COLOUR_PRESS : COLOUR_GARB;
  endfunction

endpackage

// File: rtl/lane_map.sv
// Combinational mapping from (item, position) to sprite origin and validity.
// Positions 4 and 5 fold back onto lanes 2 and 1.
module lane_map
  import plotter_pkg::*;
(
  input  logic       item,
  input  logic [2:0] position,
  output logic [7:0] x0,
  output logic [6:0] y0,
  output logic       valid
);
  logic [1:0] lane;

  // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
  always_comb begin
    lane  = (position <= 3'd3) ? position[1:0] : 2'(3'd6 - position);
    x0    = LANE_BASE + LANE_PITCH * {6'd0, lane};
    y0    = item ? PRESS_Y0 : GARB_Y0;
    valid = item ? (position <= PRESS_MAX_POS) : (position <= GARB_MAX_POS);
  end

endmodule

// File: rtl/sprite_plotter.sv
// Draws a press or garbage sprite into a 160x120 vga_adapter, one pixel per clock.
// Optional feature: define PLOTTER_PENDING_EN for a one-entry request buffer.
module sprite_plotter
  import plotter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       item,
  input  logic       erase,
  input  logic [2:0] position,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  state_t     state;
  req_t       live;
  req_t       sel;
  logic       launch;
  logic [7:0] org_x;
  logic [6:0] org_y;
  logic       org_valid;
  logic [7:0] base_x;
  logic [3:0] dx;
  logic [3:0] dy;
  logic [3:0] last_idx;

  assign live = '{item: item, erase: erase, position: position};

`ifdef PLOTTER_PENDING_EN
  req_t pend;
  logic pend_valid;

  // A buffered request takes priority when DONE hands over to the next draw.
  assign ready  = !pend_valid;
  assign sel    = pend_valid ? pend : live;
  assign launch = ((state == IDLE) && req) || ((state == DONE) && (pend_valid || req));
`else
  assign ready  = (state == IDLE);
  assign sel    = live;
  assign launch = (state == IDLE) && req;
`endif

  lane_map u_lane_map (
    .item     (sel.item),
    .position (sel.position),
    .x0       (org_x),
    .y0       (org_y),
    .valid    (org_valid)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      plot     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      base_x   <= '0;
      dx       <= '0;
      dy       <= '0;
      last_idx <= '0;
`ifdef PLOTTER_PENDING_EN
      pend       <= '0;
      pend_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          plot  <= 1'b0;
          if (launch) begin
            if (org_valid) begin
              state    <= PLOT;
              plot     <= 1'b1;
              x        <= org_x;
              y        <= org_y;
              base_x   <= org_x;
              colour   <= sprite_colour(sel.item, sel.erase);
              dx       <= '0;
              dy       <= '0;
              last_idx <= last_index(sel.item);
            end else begin
              err <= 1'b1;
            end
          end
        end
        PLOT: begin
          if (dx == last_idx) begin
            dx <= '0;
            x  <= base_x;
            if (dy == last_idx) begin
              state <= DONE;
              plot  <= 1'b0;
              done  <= 1'b1;
            end else begin
              dy <= dy + 4'd1;
              y  <= y + 7'd1;
            end
          end else begin
            dx <= dx + 4'd1;
            x  <= x + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef PLOTTER_PENDING_EN
      if ((state == PLOT) && req && !pend_valid) begin
        pend       <= live;
        pend_valid <= 1'b1;
      end else if ((state == DONE) && pend_valid) begin
        pend_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: vector table plus hand sequences, pixel scoreboard.
// Honours PLOTTER_PENDING_EN to choose the expected buffering behaviour.
module tb_sprite_plotter;

`ifdef PLOTTER_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       req;
  logic       item;
  logic       erase;
  logic [2:0] position;
  logic       ready;
  logic       done;
  logic       err;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  sprite_plotter dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .item     (item),
    .erase    (erase),
    .position (position),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    bit         last;
  } pix_t;

  typedef struct {
    bit         item;
    bit         erase;
    logic [2:0] pos;
    bit         valid;
    logic [7:0] x0;
    logic [6:0] y0;
    int         size;
    logic [2:0] colour;
  } vec_t;

  pix_t exp_q[$];
  pix_t mon_p;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   exp_done    = 1'b0;
  bit   exp_err     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Scoreboard: every plotted pixel must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset) begin
      check("done", done, exp_done);
      exp_done = 1'b0;
      check("err", err, exp_err);
      exp_err = 1'b0;
      if (plot) begin
        if (exp_q.size() == 0) begin
          check("unexpected_plot", plot, 0);
        end else begin
          mon_p = exp_q.pop_front();
          check("pix_x", x, mon_p.x);
          check("pix_y", y, mon_p.y);
          check("pix_colour", colour, mon_p.colour);
          exp_done = mon_p.last;
        end
      end
    end
  end

  task automatic push_sprite(input logic [7:0] x0, input logic [6:0] y0, input int size,
                             input logic [2:0] col);
    pix_t p;
    for (int dy = 0; dy < size; dy++) begin
      for (int dx = 0; dx < size; dx++) begin
        p.x      = x0 + 8'(dx);
        p.y      = y0 + 7'(dy);
        p.colour = col;
        p.last   = (dx == size - 1) && (dy == size - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Holds req for one clock; 'accept' says whether the DUT is expected to take it.
  task automatic do_req(input vec_t v, input bit accept);
    @(posedge clock);
    #1;
    item     = v.item;
    erase    = v.erase;
    position = v.pos;
    req      = 1'b1;
    if (accept && v.valid) push_sprite(v.x0, v.y0, v.size, v.colour);
    @(posedge clock);
    #1;
    req = 1'b0;
    if (accept && !v.valid) exp_err = 1'b1;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 600 && (exp_q.size() != 0 || exp_done || exp_err); i++) begin
      @(negedge clock);
      #1;
    end
    check("drain_timeout", (i < 600), 1);
  endtask

  vec_t tbl[11];

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    item     = 1'b0;
    erase    = 1'b0;
    position = 3'd0;

    //               item erase pos  valid x0    y0    size colour
    tbl[0]  = '{1'b1, 1'b0, 3'd5, 1'b1, 8'd56,  7'd16, 16, 3'b100};
    tbl[1]  = '{1'b0, 1'b1, 3'd3, 1'b1, 8'd120, 7'd80, 8,  3'b000};
    tbl[2]  = '{1'b0, 1'b0, 3'd4, 1'b0, 8'd0,   7'd0,  0,  3'b000};
    tbl[3]  = '{1'b1, 1'b0, 3'd4, 1'b1, 8'd88,  7'd16, 16, 3'b100};
    tbl[4]  = '{1'b1, 1'b1, 3'd0, 1'b1, 8'd24,  7'd16, 16, 3'b000};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 8'd24,  7'd80, 8,  3'b010};
    tbl[6]  = '{1'b1, 1'b0, 3'd6, 1'b0, 8'd0,   7'd0,  0,  3'b000};
    tbl[7]  = '{1'b1, 1'b0, 3'd7, 1'b0, 8'd0,   7'd0,  0,  3'b000};
    tbl[8]  = '{1'b0, 1'b0, 3'd2, 1'b1, 8'd88,  7'd80, 8,  3'b010};
    tbl[9]  = '{1'b1, 1'b0, 3'd3, 1'b1, 8'd120, 7'd16, 16, 3'b100};
    tbl[10] = '{1'b0, 1'b0, 3'd5, 1'b0, 8'd0,   7'd0,  0,  3'b000};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", ready, 1);
    check("rst_plot", plot, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Table-driven draws and rejections
    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i], 1'b1);
      @(negedge clock);
      check("first_plot", plot, tbl[i].valid);
      check("ready_after_accept", ready, tbl[i].valid ? PEND : 1'b1);
      wait_drain();
    end

    // Reset in the middle of a press draw, after 100 pixels
    begin
      vec_t v;
      int   i;
      v = '{1'b1, 1'b0, 3'd0, 1'b1, 8'd24, 7'd16, 16, 3'b100};
      do_req(v, 1'b1);
      for (i = 0; i < 400 && exp_q.size() > 156; i++) begin
        @(negedge clock);
        #1;
      end
      check("abort_reach_px100", (i < 400), 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      exp_q.delete();
      exp_done = 1'b0;
      @(negedge clock);
      check("abort_plot", plot, 0);
      check("abort_ready", ready, 1);
      check("abort_done", done, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (300) @(posedge clock);
      check("abort_quiet", exp_q.size(), 0);
    end

    // Second request while the first is still plotting
    begin
      vec_t a;
      vec_t b;
      int   i;
      a = '{1'b1, 1'b0, 3'd1, 1'b1, 8'd56, 7'd16, 16, 3'b100};
      b = '{1'b0, 1'b0, 3'd2, 1'b1, 8'd88, 7'd80, 8,  3'b010};
      do_req(a, 1'b1);
      repeat (20) @(posedge clock);
      do_req(b, PEND);
      @(negedge clock);
      check("pend_ready_low", ready, 0);
      for (i = 0; i < 400 && done !== 1'b1; i++) @(negedge clock);
      check("pend_first_done", done, 1);
      @(negedge clock);
      check("pend_second_start", plot, PEND);
      wait_drain();
      repeat (5) @(posedge clock);
      check("pend_idle_ready", ready, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
